// File: rtl/mips_pkg.sv
// mips_pkg: MIPS32 opcode/funct constants, request-kind encoding and loader states
// shared by the instruction loader and the main control decoder.
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    typedef enum logic [2:0] {KIND_R, KIND_LW, KIND_SW, KIND_BEQ, KIND_ADDI, KIND_J} kind_t;
    typedef enum logic {ST_LOAD, ST_FULL} ld_state_t;
    function automatic logic funct_ok(input logic [5:0] fn);
        return fn == FN_ADD || fn == FN_SUB || fn == FN_AND || fn == FN_OR || fn == FN_SLT;
    endfunction
endpackage

// File: rtl/instr_loader_if.sv
// instr_loader_if: field-level instruction request channel (valid/ready).
interface instr_loader_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_kind;
    logic [4:0]  req_rs, req_rt, req_rd, req_shamt;
    logic [5:0]  req_funct;
    logic [15:0] req_imm;
    logic [25:0] req_target;
    modport master (output req_valid, req_kind, req_rs, req_rt, req_rd, req_shamt,
                    req_funct, req_imm, req_target, input req_ready);
    modport slave  (input req_valid, req_kind, req_rs, req_rt, req_rd, req_shamt,
                    req_funct, req_imm, req_target, output req_ready);
endinterface

// File: rtl/instr_pack.sv
// instr_pack: combinational fields-to-word MIPS32 encoder with a legal flag.
// ENC_CHECK_EN: also reject R-type functs outside add/sub/and/or/slt.
module instr_pack
    import mips_pkg::*;
(
    input  logic [2:0]  i_kind,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_shamt,
    input  logic [5:0]  i_funct,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_target,
    output logic [31:0] o_word,
    output logic        o_legal
);
    logic [5:0] w_op;
    always_comb begin
        w_op = i_kind == KIND_LW   ? OP_LW   :
               i_kind == KIND_SW   ? OP_SW   :
               i_kind == KIND_BEQ  ? OP_BEQ  :
               i_kind == KIND_ADDI ? OP_ADDI :
               i_kind == KIND_J    ? OP_J    : OP_RTYPE;
        o_word = i_kind == KIND_R ? {w_op, i_rs, i_rt, i_rd, i_shamt, i_funct} :
                 i_kind == KIND_J ? {w_op, i_target} : {w_op, i_rs, i_rt, i_imm};
`ifdef ENC_CHECK_EN
        o_legal = i_kind <= KIND_J && (i_kind != KIND_R || funct_ok(i_funct));
`else
        o_legal = i_kind <= KIND_J;
`endif
    end
endmodule

// File: rtl/instr_loader.sv
// instr_loader: accepts encoded instruction requests and writes them to consecutive
// imem words. ENC_CHECK_EN: also reject bad functs and J targets >= DEPTH.
module instr_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    instr_loader_if.slave     req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;
    logic              r_we, r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_count;
    logic [31:0]       w_word;
    logic              w_pk_legal, w_legal, w_ready, w_acc;
    ld_state_t         w_state;
    instr_pack u_pack (
        .i_kind(req.req_kind), .i_rs(req.req_rs), .i_rt(req.req_rt), .i_rd(req.req_rd),
        .i_shamt(req.req_shamt), .i_funct(req.req_funct), .i_imm(req.req_imm),
        .i_target(req.req_target), .o_word(w_word), .o_legal(w_pk_legal)
    );
    // The J target range depends on the memory depth, so it is checked here.
    always_comb begin
        w_state = r_count == DEPTH ? ST_FULL : ST_LOAD;
        w_ready = w_state == ST_LOAD && !clear;
`ifdef ENC_CHECK_EN
        w_legal = w_pk_legal && (req.req_kind != KIND_J || (req.req_target >> ADDR_W) == '0);
`else
        w_legal = w_pk_legal;
`endif
        w_acc = req.req_valid && w_ready;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_we <= w_acc && w_legal;
            if (clear) begin
                r_count <= '0;
                r_err   <= 1'b0;
            end else if (w_acc && w_legal) begin
                r_addr  <= r_count[ADDR_W-1:0];
                r_wdata <= w_word;
                r_count <= r_count + 1'b1;
            end else if (w_acc) begin
                r_err <= 1'b1;
            end
        end
    end
    assign req.req_ready = w_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign full       = w_state == ST_FULL;
    assign err        = r_err;
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed and randomized checks of instr_loader against an
// arithmetic reference model; a second ADDR_W=2 instance covers the fill boundary.
module tb_instr_loader;
    localparam int AW = 6;
    localparam int DEPTH = 64;
    logic clk = 0, rst_n = 0, clear = 0, s_clear = 0;
    always #5 clk = ~clk;
    instr_loader_if mif();
    instr_loader_if sif();
    logic          we, full, err;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [AW:0]   cnt;
    logic          s_we, s_full, s_err;
    logic [1:0]    s_addr;
    logic [31:0]   s_wdata;
    logic [2:0]    s_cnt;
    instr_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .req(mif),
        .imem_we(we), .imem_addr(addr), .imem_wdata(wdata),
        .count(cnt), .full(full), .err(err)
    );
    instr_loader #(.ADDR_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .clear(s_clear), .req(sif),
        .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
        .count(s_cnt), .full(s_full), .err(s_err)
    );
    int total = 0, bad = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    function automatic logic [31:0] m_enc(input int k, rs, rt, rd, sh, fn, imm, tgt);
        int ops[6] = '{0, 35, 43, 4, 8, 2};
        longint w;
        w = longint'(ops[k]) * 64'h4000000;
        if (k == 0) w += rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + fn;
        else if (k == 5) w += tgt;
        else w += rs * 2097152 + rt * 65536 + imm;
        return w[31:0];
    endfunction
    function automatic bit m_legal(input int k, fn, tgt);
`ifdef ENC_CHECK_EN
        return k < 6 && (k != 0 || fn inside {32, 34, 36, 37, 42}) && (k != 5 || tgt < DEPTH);
`else
        return k < 6 && fn >= 0 && tgt >= 0;
`endif
    endfunction
    int m_count = 0, m_addr = 0;
    bit m_we = 0, m_err = 0, m_took = 0;
    logic [31:0] m_wdata = 0;
    int k_i, rs_i, rt_i, rd_i, sh_i, fn_i, imm_i, tgt_i;
    always_comb begin
        k_i = int'(mif.req_kind); rs_i = int'(mif.req_rs); rt_i = int'(mif.req_rt);
        rd_i = int'(mif.req_rd); sh_i = int'(mif.req_shamt); fn_i = int'(mif.req_funct);
        imm_i = int'(mif.req_imm); tgt_i = int'(mif.req_target);
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count <= 0; m_we <= 0; m_err <= 0; m_took <= 0;
        end else begin
            m_took <= mif.req_valid && !clear && m_count < DEPTH;
            m_we   <= mif.req_valid && !clear && m_count < DEPTH && m_legal(k_i, fn_i, tgt_i);
            if (clear) begin
                m_count <= 0; m_err <= 0;
            end else if (mif.req_valid && m_count < DEPTH) begin
                if (m_legal(k_i, fn_i, tgt_i)) begin
                    m_addr  <= m_count;
                    m_wdata <= m_enc(k_i, rs_i, rt_i, rd_i, sh_i, fn_i, imm_i, tgt_i);
                    m_count <= m_count + 1;
                end else m_err <= 1;
            end
        end
    end
    initial forever begin
        @(negedge clk); #2;
        chk("we", 64'(we), 64'(m_we));
        if (m_we) begin
            chk("addr", 64'(addr), 64'(m_addr));
            chk("wdata", 64'(wdata), 64'(m_wdata));
        end
        chk("count", 64'(cnt), 64'(m_count));
        chk("full", 64'(full), 64'(m_count == DEPTH));
        chk("err", 64'(err), 64'(m_err));
        chk("ready", 64'(mif.req_ready), 64'(m_count != DEPTH && !clear));
    end
    task automatic step();
        @(negedge clk); #1;
    endtask
    task automatic drv(input int k, rs, rt, rd, sh, fn, imm, tgt);
        mif.req_kind = 3'(k); mif.req_rs = 5'(rs); mif.req_rt = 5'(rt); mif.req_rd = 5'(rd);
        mif.req_shamt = 5'(sh); mif.req_funct = 6'(fn); mif.req_imm = 16'(imm);
        mif.req_target = 26'(tgt); mif.req_valid = 1;
    endtask
    task automatic clr();
        mif.req_valid = 0; clear = 1; step(); clear = 0;
    endtask
    initial begin
        drv(0, 0, 0, 0, 0, 0, 0, 0); mif.req_valid = 0;
        sif.req_valid = 0; sif.req_kind = 3'd4; sif.req_rs = 0; sif.req_rt = 5'd1;
        sif.req_rd = 0; sif.req_shamt = 0; sif.req_funct = 0; sif.req_imm = 16'd5; sif.req_target = 0;
        repeat (3) step();
        chk("rst_we", 64'(we), 0); chk("rst_addr", 64'(addr), 0); chk("rst_wdata", 64'(wdata), 0);
        chk("rst_count", 64'(cnt), 0); chk("rst_full", 64'(full), 0); chk("rst_err", 64'(err), 0);
        rst_n = 1; step();
        chk("rst_ready", 64'(mif.req_ready), 1);
        drv(4, 0, 1, 0, 0, 0, 5, 0); step(); mif.req_valid = 0;
        chk("addi_we", 64'(we), 1); chk("addi_addr", 64'(addr), 0);
        chk("addi_wdata", 64'(wdata), 64'h20010005); chk("addi_count", 64'(cnt), 1);
        clr();
        drv(1, 1, 2, 0, 0, 0, 4, 0); step();
        chk("lw_wdata", 64'(wdata), 64'h8C220004); chk("lw_addr", 64'(addr), 0);
        drv(0, 1, 2, 3, 0, 32, 0, 0); step();
        chk("add_wdata", 64'(wdata), 64'h00221820); chk("add_addr", 64'(addr), 1);
        drv(3, 1, 2, 0, 0, 0, 16'hFFFF, 0); step();
        chk("beq_wdata", 64'(wdata), 64'h1022FFFF); chk("beq_addr", 64'(addr), 2);
        drv(5, 0, 0, 0, 0, 0, 0, 'h10); step();
        chk("j_wdata", 64'(wdata), 64'h08000010); chk("j_addr", 64'(addr), 3);
        chk("b2b_we", 64'(we), 1); chk("b2b_count", 64'(cnt), 4);
        clr();
        drv(4, 0, 1, 0, 0, 0, 5, 0); step();
        drv(7, 1, 2, 3, 0, 32, 9, 0); step();
        chk("ill_we", 64'(we), 0); chk("ill_err", 64'(err), 1);
        drv(4, 0, 2, 0, 0, 0, 6, 0); step(); mif.req_valid = 0;
        chk("ill2_addr", 64'(addr), 1); chk("ill2_wdata", 64'(wdata), 64'h20020006);
        chk("ill2_count", 64'(cnt), 2);
        clr();
        drv(0, 1, 2, 3, 0, 0, 0, 0); step(); mif.req_valid = 0;
`ifdef ENC_CHECK_EN
        chk("fn0_we", 64'(we), 0); chk("fn0_err", 64'(err), 1);
`else
        chk("fn0_we", 64'(we), 1); chk("fn0_wdata", 64'(wdata), 64'h00221800);
`endif
        step();
        drv(4, 0, 1, 0, 0, 0, 5, 0); step();
        rst_n = 0; #1;
        chk("midrst_we", 64'(we), 0); chk("midrst_count", 64'(cnt), 0);
        mif.req_valid = 0; step(); rst_n = 1; step();
        for (int c = 0; c < 4000; c++) begin
            clear = $urandom_range(0, 119) == 0;
            if (!mif.req_valid || m_took) begin
                if ($urandom_range(0, 3) == 0) mif.req_valid = 0;
                else drv($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                         $urandom_range(0, 31), $urandom_range(0, 31),
                         $urandom_range(0, 3) == 0 ? $urandom_range(0, 63) : 32 + 2 * $urandom_range(0, 5),
                         $urandom_range(0, 65535),
                         $urandom_range(0, 1) ? $urandom_range(0, 127) : $urandom_range(0, 67108863));
            end
            step();
        end
        clear = 0; mif.req_valid = 0; step();
        sif.req_kind = 3'd7; sif.req_valid = 1; step();
        chk("s_ill_err", 64'(s_err), 1); chk("s_ill_we", 64'(s_we), 0);
        sif.req_kind = 3'd4;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("s_fill_we", 64'(s_we), 1); chk("s_fill_addr", 64'(s_addr), 64'(i));
        end
        chk("s_fill_wdata", 64'(s_wdata), 64'h20010005);
        chk("s_full", 64'(s_full), 1); chk("s_ready", 64'(sif.req_ready), 0);
        chk("s_count", 64'(s_cnt), 4);
        step(); step();
        chk("s_held_we", 64'(s_we), 0); chk("s_held_count", 64'(s_cnt), 4);
        s_clear = 1; step();
        chk("s_clr_count", 64'(s_cnt), 0); chk("s_clr_full", 64'(s_full), 0);
        chk("s_clr_err", 64'(s_err), 0); chk("s_clr_we", 64'(s_we), 0);
        s_clear = 0; step();
        chk("s_after_we", 64'(s_we), 1); chk("s_after_addr", 64'(s_addr), 0);
        sif.req_valid = 0; step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_loader.md
# instr_loader

Sequential MIPS32 instruction encoder and loader. Accepts field-level instruction requests over a valid/ready handshake, assembles each into a 32-bit instruction word (R, I and J formats), and writes the words to consecutive instruction-memory locations. It drives the instruction-memory write port during bring-up and test, producing exactly the opcode set the main control decoder consumes: R-type, lw, sw, beq, addi and j.

## Interface
- ADDR_W, 6: instruction-memory word-address width; DEPTH = 2^ADDR_W words.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous restart: load pointer to 0, error flag cleared.
- req_valid  in  1  request present.
- req_ready  out  1  loader can accept a request.
- req_kind  in  3  0=R, 1=LW, 2=SW, 3=BEQ, 4=ADDI, 5=J, 6–7 illegal.
- req_rs, req_rt, req_rd, req_shamt  in  5 each  register/shift fields.
- req_funct  in  6  R-type function code.
- req_imm  in  16  I-type immediate/offset.
- req_target  in  26  J-type word target.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written since reset/clear.
- full  out  1  count == DEPTH.
- err  out  1  sticky: an illegal request was rejected.

## Operation
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- Formats: R {op,rs,rt,rd,shamt,funct}; LW/SW/BEQ/ADDI {op,rs,rt,imm}; J {op,target}. Unused request fields are ignored.
- req_ready = !full && !clear (combinational).
- Handshake: a request is accepted on any rising edge with req_valid && req_ready. The requester holds its fields stable until it is accepted.
- Legal accept: the word is registered to imem_wdata. imem_addr = count[ADDR_W-1:0] before the increment. imem_we = 1 for exactly one cycle. count increments by 1.
- Illegal accept (kind 6–7, or a failed check under the configuration macro): the request is consumed, no write occurs, count is unchanged, and err is set.
- States, derived from count: LOAD (count < DEPTH) and FULL. FULL is exited only by clear or reset.
- Simultaneous clear and req_valid: clear wins. No accept takes place, count becomes 0, err becomes 0, and imem_we is 0 on the next cycle.
- Reset mid-stream: all outputs return to their reset values immediately. A write in flight is dropped.

## Timing
- Reset values: imem_we 0, imem_addr 0, imem_wdata 0, count 0, full 0, err 0. req_ready is 1 once rst_n is high and clear is low.
- Latency: accept at edge N; imem_we, imem_addr and imem_wdata are valid during cycle N+1, sampled by memory at edge N+1.
- Throughput: one request per cycle, with back-to-back accepts producing back-to-back writes.
- full and count update at the accepting edge, so req_ready falls in the cycle after the DEPTH-th legal accept. A write never goes past address DEPTH-1, and the address never wraps.
- err is set at the edge that accepts an illegal request and is visible in the next cycle.

## Configuration
- ENC_CHECK_EN defined: R-type funct must be one of add 100000, sub 100010, and 100100, or 100101, slt 101010. J target must be < DEPTH. A violation is treated as an illegal request.
- ENC_CHECK_EN undefined: funct and target are passed through unchecked. Only kinds 6–7 are illegal.

## Structure
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - funct constants;
  - the req_kind encoding (KIND_R … KIND_J).
- The control decoder imports the same opcode constants from mips_pkg.
- Sub-module instr_pack: combinational fields-to-word encoder with a legal flag.
- instr_loader holds the handshake, pointer, output register and error flag.

## Test plan
- addi $1,$0,5 (kind 4, rs 0, rt 1, imm 5) after reset -> cycle N+1: imem_we 1, addr 0, wdata 0x20010005; count 1.
- Back-to-back: lw $2,4($1); add $3,$1,$2; beq $1,$2,-1; j 0x10 -> consecutive writes at addr 0–3:
  - wdata 0x8C220004;
  - wdata 0x00221820;
  - wdata 0x1022FFFF;
  - wdata 0x08000010.
- ADDR_W=2 with 5 valid requests held -> 4 writes (addr 0–3), full 1, req_ready 0 from the cycle after the 4th accept, 5th request never accepted.
- kind 7 between two legal requests -> no write for it, err 1, count 2, second legal request written at addr 1.
- clear asserted together with req_valid while full -> no accept, count 0, full 0, err 0, next request written at addr 0.
- ENC_CHECK_EN with R-type funct 000000 -> err 1, no write. Without the macro -> word 0x00221800 written.
